// File: rtl/axis_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axis_sync_fifo
// Purpose  : Single-clock AXI4-Stream FIFO with synchronous flush. Ready on
//            the input side depends only on stored occupancy and the flush
//            input, so downstream back-pressure never reaches the producer
//            combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module axis_sync_fifo #(
    parameter int TDATA_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    // input stream
    input  logic                         s_tvalid_i,
    input  logic [TDATA_WIDTH-1:0]       s_tdata_i,
    output logic                         s_tready_o,
    // output stream
    output logic                         m_tvalid_o,
    output logic [TDATA_WIDTH-1:0]       m_tdata_o,
    input  logic                         m_tready_i,
    // flush and status
    input  logic                         invalidate_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    // Storage is deliberately left without reset; only the pointers matter.
    logic [TDATA_WIDTH-1:0] mem_q [DEPTH];

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] w_occ;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    // Occupancy and status flags derived purely from the registered pointers.
    always_comb begin
        w_occ   = wptr_q - rptr_q;
        w_empty = (wptr_q == rptr_q);
        w_full  = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) &&
                  (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]);
    end

    // Handshake outputs; a flush in progress blocks both sides.
    always_comb begin
        s_tready_o = !w_full && !invalidate_i;
        m_tvalid_o = !w_empty && !invalidate_i;
        m_tdata_o  = mem_q[rptr_q[ADDR_W-1:0]];
        count_o    = CNT_W'(w_occ);
        w_push     = s_tvalid_i && s_tready_o;
        w_pop      = m_tvalid_o && m_tready_i;
    end

    // Next pointer values; a flush snaps the read pointer onto the write pointer.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (invalidate_i) begin
            rptr_d = wptr_q;
        end else begin
            if (w_push) wptr_d = wptr_q + PTR_W'(1);
            if (w_pop)  rptr_d = rptr_q + PTR_W'(1);
        end
    end

    // Pointer registers with asynchronous reset to the empty state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Array write on an accepted input beat.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wptr_q[ADDR_W-1:0]] <= s_tdata_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_sync_fifo
// Purpose  : Self-checking bench for axis_sync_fifo using a queue-based
//            reference model and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_sync_fifo;

    localparam int TDATA_WIDTH = 32;
    localparam int DEPTH       = 4;
    localparam int CNT_W       = $clog2(DEPTH + 1);

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   s_tvalid_i;
    logic [TDATA_WIDTH-1:0] s_tdata_i;
    logic                   s_tready_o;
    logic                   m_tvalid_o;
    logic [TDATA_WIDTH-1:0] m_tdata_o;
    logic                   m_tready_i;
    logic                   invalidate_i;
    logic [CNT_W-1:0]       count_o;

    axis_sync_fifo #(
        .TDATA_WIDTH (TDATA_WIDTH),
        .DEPTH       (DEPTH)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .s_tvalid_i   (s_tvalid_i),
        .s_tdata_i    (s_tdata_i),
        .s_tready_o   (s_tready_o),
        .m_tvalid_o   (m_tvalid_o),
        .m_tdata_o    (m_tdata_o),
        .m_tready_i   (m_tready_i),
        .invalidate_i (invalidate_i),
        .count_o      (count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    logic [TDATA_WIDTH-1:0] model_q [$];
    logic [TDATA_WIDTH-1:0] in_log  [$];
    logic [TDATA_WIDTH-1:0] out_log [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO semantics on a queue, updated on each rising edge.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            if (invalidate_i) begin
                model_q.delete();
            end else begin
                bit do_pop, do_push;
                do_pop  = (model_q.size() != 0) && m_tready_i;
                do_push = s_tvalid_i && (model_q.size() < DEPTH);
                if (do_pop)  void'(model_q.pop_front());
                if (do_push) begin
                    model_q.push_back(s_tdata_i);
                    in_log.push_back(s_tdata_i);
                end
            end
        end
    end

    // Asynchronous reset empties the model at once.
    always @(negedge rst_ni) model_q.delete();

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk_i) begin
        bit exp_v, exp_r;
        exp_v = (model_q.size() != 0) && !invalidate_i && rst_ni;
        exp_r = (model_q.size() < DEPTH) && !invalidate_i;
        chk("m_tvalid", 32'(m_tvalid_o), 32'(exp_v));
        chk("s_tready", 32'(s_tready_o), 32'(exp_r));
        chk("count", 32'(count_o), 32'(model_q.size()));
        if (exp_v) chk("m_tdata", m_tdata_o, model_q[0]);
        if (count_o > CNT_W'(DEPTH)) chk("count_bound", 32'(count_o), 32'(DEPTH));
        if (m_tvalid_o && m_tready_i) out_log.push_back(m_tdata_o);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        s_tvalid_i   = 1'b0;
        s_tdata_i    = '0;
        m_tready_i   = 1'b0;
        invalidate_i = 1'b0;
    endtask

    // Push one word with output side stalled.
    task automatic push_word(input logic [31:0] d);
        s_tvalid_i = 1'b1;
        s_tdata_i  = d;
        tick();
        s_tvalid_i = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        m_tready_i = 1'b1;
        while (m_tvalid_o && n < max_cycles) begin
            tick();
            n++;
        end
        m_tready_i = 1'b0;
        if (m_tvalid_o) chk("drain_timeout", 32'(m_tvalid_o), 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        #1;
        chk("rst_tvalid", 32'(m_tvalid_o), 32'd0);
        chk("rst_tready", 32'(s_tready_o), 32'd1);
        chk("rst_count", 32'(count_o), 32'd0);
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();

        // Fill then drain
        out_log.delete();
        for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
        chk("fill_count", 32'(count_o), 32'd4);
        chk("fill_tready", 32'(s_tready_o), 32'd0);
        m_tready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(m_tvalid_o), 32'd1);
            chk("drain_data", m_tdata_o, 32'hA0 + 32'(i));
            tick();
        end
        m_tready_i = 1'b0;
        chk("drain_count", 32'(count_o), 32'd0);
        chk("drain_tvalid", 32'(m_tvalid_o), 32'd0);
        chk("drain_log_n", 32'(out_log.size()), 32'd4);

        // Streaming with wrap
        out_log.delete();
        m_tready_i = 1'b1;
        s_tvalid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_tdata_i = 32'(i);
            tick();
            chk("stream_count", 32'(count_o), 32'd1);
            chk("stream_data", m_tdata_o, 32'(i));
        end
        s_tvalid_i = 1'b0;
        tick();
        m_tready_i = 1'b0;
        chk("stream_log_n", 32'(out_log.size()), 32'd16);
        for (int i = 0; i < 16 && i < out_log.size(); i++)
            chk("stream_order", out_log[i], 32'(i));

        // Full plus simultaneous pop
        out_log.delete();
        for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
        m_tready_i = 1'b1;
        chk("fullpop_tready_same", 32'(s_tready_o), 32'd0);
        tick();
        m_tready_i = 1'b0;
        chk("fullpop_tready_next", 32'(s_tready_o), 32'd1);
        chk("fullpop_count", 32'(count_o), 32'd3);
        chk("fullpop_word", (out_log.size() > 0) ? out_log[0] : 32'hDEAD, 32'hA0);
        drain(10);

        // Random back-pressure, 1000 words
        begin
            int sent, cyc;
            in_log.delete();
            out_log.delete();
            sent = 0;
            cyc  = 0;
            while (sent < 1000 && cyc < 20000) begin
                s_tvalid_i = 1'($urandom_range(0, 1));
                m_tready_i = 1'($urandom_range(0, 1));
                s_tdata_i  = 32'h1000 + 32'(sent);
                if (s_tvalid_i && s_tready_o) sent++;
                tick();
                cyc++;
            end
            s_tvalid_i = 1'b0;
            if (sent < 1000) chk("rand_timeout", 32'(sent), 32'd1000);
            drain(20);
            chk("rand_in_n", 32'(in_log.size()), 32'd1000);
            chk("rand_out_n", 32'(out_log.size()), 32'd1000);
            for (int i = 0; i < 1000 && i < out_log.size(); i++)
                if (out_log[i] !== 32'h1000 + 32'(i)) chk("rand_order", out_log[i], 32'h1000 + 32'(i));
        end

        // Flush with count = 3
        out_log.delete();
        for (int i = 0; i < 3; i++) push_word(32'hB0 + 32'(i));
        chk("flush_pre_count", 32'(count_o), 32'd3);
        invalidate_i = 1'b1;
        s_tvalid_i   = 1'b1;
        s_tdata_i    = 32'h99;
        m_tready_i   = 1'b1;
        #1;
        chk("flush_tready", 32'(s_tready_o), 32'd0);
        chk("flush_tvalid", 32'(m_tvalid_o), 32'd0);
        tick();
        invalidate_i = 1'b0;
        s_tvalid_i   = 1'b0;
        m_tready_i   = 1'b0;
        #1;
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_post_tvalid", 32'(m_tvalid_o), 32'd0);
        chk("flush_post_tready", 32'(s_tready_o), 32'd1);
        push_word(32'h55);
        chk("flush_first_valid", 32'(m_tvalid_o), 32'd1);
        chk("flush_first_data", m_tdata_o, 32'h55);
        drain(5);
        chk("flush_log_n", 32'(out_log.size()), 32'd1);
        chk("flush_log0", (out_log.size() > 0) ? out_log[0] : 32'hDEAD, 32'h55);

        // Reset mid-operation with count = 2
        out_log.delete();
        push_word(32'h11);
        push_word(32'h22);
        chk("rstmid_pre_count", 32'(count_o), 32'd2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rstmid_tvalid", 32'(m_tvalid_o), 32'd0);
        chk("rstmid_count", 32'(count_o), 32'd0);
        chk("rstmid_tready", 32'(s_tready_o), 32'd1);
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
        push_word(32'h77);
        drain(5);
        chk("rstmid_log_n", 32'(out_log.size()), 32'd1);
        chk("rstmid_log0", (out_log.size() > 0) ? out_log[0] : 32'hDEAD, 32'h77);
        chk("rstmid_end_count", 32'(count_o), 32'd0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_sync_fifo.md
# axis_sync_fifo

Synchronous AXI4-Stream FIFO with flush, placed directly upstream of axis_skid_buffer in the fetch/decode pipeline. It absorbs bursts from the producing stage and decouples its ready from downstream back-pressure. Its invalidate input is tied to the same redirect/flush signal that drives the skid buffer, so both stages discard in-flight data on the same edge.

## Interface
- TDATA_WIDTH, 32, payload width
- DEPTH, 4, number of entries; power of two, minimum 2
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- axis_sif  slave  axis_if(TDATA_WIDTH)  input stream: tvalid, tdata in; tready out
- axis_mif  master  axis_if(TDATA_WIDTH)  output stream: tvalid, tdata out; tready in
- invalidate  input  1  synchronous flush of all stored entries
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH-entry register array, plus write and read pointers of $clog2(DEPTH)+1 bits each. The extra MSB disambiguates full from empty.
- empty: wptr == rptr. full: low bits equal and MSBs differ. count = wptr - rptr, computed modulo 2^(ptr width).
- axis_sif.tready = !full && !invalidate. It depends only on registered state and invalidate, never on axis_mif.tready.
- axis_mif.tvalid = !empty && !invalidate.
- axis_mif.tdata = mem[rptr low bits]; driven combinationally from the array. The value is held stable while tvalid is high and tready is low.
- Push: when axis_sif.tvalid && axis_sif.tready, write tdata to mem[wptr] and increment wptr.
- Pop: when axis_mif.tvalid && axis_mif.tready, increment rptr.
- Simultaneous push and pop (not full, not empty): both pointers advance and count is unchanged.
- Full: no push; a pop in that cycle frees one slot, and tready rises on the next cycle. Ready is never raised in the same cycle as the pop.
- Empty: no pop. Pushed data becomes visible on the next cycle; there is no fall-through bypass.
- Pointer wrap: pointers are allowed to overflow naturally. Entry order is preserved across wrap.
- invalidate:
  - In the cycle it is asserted, no transfer occurs on either side.
  - At the next edge, rptr takes the value of wptr, so the FIFO becomes empty and count = 0.
  - Array contents are not cleared.
  - invalidate has priority over every push and pop in the same cycle.
- Reset (rst low, asynchronous):
  - wptr = rptr = 0 and count = 0.
  - axis_mif.tvalid = 0 and axis_sif.tready = 1 immediately, without waiting for a clock edge.
  - The array is not reset.
  - Reset asserted mid-burst discards all entries; no partial transfer is completed.

## Timing
- Latency from push to the entry appearing at the output: 1 cycle.
- Throughput: 1 transfer per cycle on each side, sustained, when the FIFO is neither full nor empty.
- Reset values: axis_mif.tvalid = 0, axis_mif.tdata = don't-care (array not reset), axis_sif.tready = 1, count = 0.
- After rst deasserts, the first accepted push is on the first rising edge where sif tvalid = 1.
- count is updated on the edge following the transfer(s) that change it.
- invalidate deasserted: both tready and tvalid recompute from the post-flush state on the following cycle. In that cycle tvalid = 0 and tready = 1.

## Test plan
- Fill then drain (DEPTH=4), mif tready=0:
  - Push 0xA0..0xA3 -> tready drops after the 4th push and count = 4.
  - Raise mif tready -> outputs 0xA0, 0xA1, 0xA2, 0xA3 on 4 consecutive cycles; count returns to 0 and tvalid = 0.
- Streaming with both sides valid/ready every cycle: 16 words 0x00..0x0F -> emerge in order, 1 cycle after their push, one per cycle. count stays at 1 after the first word; pointers wrap with no loss.
- Full plus simultaneous pop: count = 4 and mif tready=1 for one cycle -> 0xA0 is popped, tready = 0 in that cycle and 1 the next; count = 3.
- Random back-pressure: random sif tvalid and mif tready (50%) over 1000 words -> output sequence equals input sequence, never more than 4 entries buffered, and tdata is stable while stalled.
- Flush: with count = 3, assert invalidate for 1 cycle while sif tvalid=1 -> no push or pop in that cycle; count = 0 next cycle; the next pushed word 0x55 is the first word output.
- Reset mid-operation: with count = 2, pull rst low between edges -> tvalid falls to 0 and count to 0 before the next edge. After release, push 0x77 -> output is 0x77 only.
